// File: rtl/complex_mult_pkg.sv
// Shared types and helpers for the pipelined complex multiplier.
// Saturation versus wrap is chosen in cmult_round_sat via COMPLEX_MULT_SAT_EN.
package complex_mult_pkg;

    localparam int DEF_IN_W  = 18;
    localparam int DEF_OUT_W = 37;
    localparam int LIM_W     = 128;

    typedef logic signed [DEF_IN_W-1:0]  in_comp_t;
    typedef logic signed [DEF_OUT_W-1:0] out_comp_t;

    typedef struct packed {
        in_comp_t re;
        in_comp_t im;
    } in_sample_t;

    typedef struct packed {
        out_comp_t re;
        out_comp_t im;
    } out_sample_t;

    // Full-precision width of a complex product sum: two IN_W products plus one carry bit.
    function automatic int full_w(input int in_w);
        return 2 * in_w + 1;
    endfunction

    // Signed OUT_W limit, returned wide so callers can slice to their compare width.
    function automatic logic signed [LIM_W-1:0] sat_limit(input int out_w, input logic neg);
        logic signed [LIM_W-1:0] one_v;
        one_v = {{(LIM_W-1){1'b0}}, 1'b1};
        if (neg) begin
            return -(one_v <<< (out_w - 1));
        end else begin
            return (one_v <<< (out_w - 1)) - one_v;
        end
    endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Round-half-up, arithmetic shift and fit-to-width for one result component.
// COMPLEX_MULT_SAT_EN defined: clamp out-of-range values; undefined: wrap to OUT_W bits.
module cmult_round_sat
    import complex_mult_pkg::*;
#(
    parameter int FULL_W = 37,
    parameter int OUT_W  = 37,
    parameter int SHIFT  = 0
) (
    input  logic signed [FULL_W-1:0] val_i,
    output logic signed [OUT_W-1:0]  res_o,
    output logic                     ovf_o
);

    localparam int EXT_W = FULL_W + 1;
    localparam logic signed [EXT_W-1:0] RND_C =
        (SHIFT > 0) ? (EXT_W'(1) <<< ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

    logic signed [EXT_W-1:0] ext_s;
    logic signed [EXT_W-1:0] scl_s;

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        ext_s = {val_i[FULL_W-1], val_i};
        scl_s = (ext_s + RND_C) >>> SHIFT;
    end

    generate
        if (OUT_W >= EXT_W) begin : g_wide
            // Output is wide enough for any scaled value.
            always_comb begin
                res_o = OUT_W'(scl_s);
                ovf_o = 1'b0;
            end
        end else begin : g_narrow
            localparam logic signed [LIM_W-1:0] HI_L = sat_limit(OUT_W, 1'b0);
            localparam logic signed [LIM_W-1:0] LO_L = sat_limit(OUT_W, 1'b1);
            localparam logic signed [EXT_W-1:0] HI_C = HI_L[EXT_W-1:0];
            localparam logic signed [EXT_W-1:0] LO_C = LO_L[EXT_W-1:0];

            // Range check and fit into OUT_W.
            always_comb begin
                ovf_o = (scl_s > HI_C) || (scl_s < LO_C);
`ifdef COMPLEX_MULT_SAT_EN
                if (scl_s > HI_C) begin
                    res_o = HI_C[OUT_W-1:0];
                end else if (scl_s < LO_C) begin
                    res_o = LO_C[OUT_W-1:0];
                end else begin
                    res_o = scl_s[OUT_W-1:0];
                end
`else
                res_o = scl_s[OUT_W-1:0];
`endif
            end
        end
    endgenerate

endmodule

// File: rtl/complex_mult_pipe.sv
// Three-stage pipelined complex multiplier (a*b or a*conj(b)) with valid/ready,
// scaling, rounding and sticky overflow; clamp enabled by COMPLEX_MULT_SAT_EN.
module complex_mult_pipe
    import complex_mult_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int OUT_W = 37,
    parameter int SHIFT = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic signed [IN_W-1:0]  data_a_i_i,
    input  logic signed [IN_W-1:0]  data_a_q_i,
    input  logic signed [IN_W-1:0]  data_b_i_i,
    input  logic signed [IN_W-1:0]  data_b_q_i,
    input  logic                    conj_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic signed [OUT_W-1:0] data_i_o,
    output logic signed [OUT_W-1:0] data_q_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    ovf_o,
    input  logic                    ovf_clr_i
);

    localparam int FULL_W = full_w(IN_W);
    localparam int PROD_W = 2 * IN_W;

    logic                     adv_s;
    logic signed [IN_W-1:0]   a_re_r, a_im_r, b_re_r, b_im_r;
    logic                     conj1_r, v1_r;
    logic signed [PROD_W-1:0] p_rr_r, p_qq_r, p_rq_r, p_qr_r;
    logic                     conj2_r, v2_r;
    logic signed [FULL_W-1:0] re_full_s, im_full_s;
    logic signed [OUT_W-1:0]  re_res_s, im_res_s;
    logic                     re_ovf_s, im_ovf_s;

    // Whole pipeline moves together; stalls only when the output is held.
    assign adv_s   = !valid_o || ready_i;
    assign ready_o = adv_s;

    // Stage 1: operand capture.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_re_r  <= '0;
            a_im_r  <= '0;
            b_re_r  <= '0;
            b_im_r  <= '0;
            conj1_r <= 1'b0;
            v1_r    <= 1'b0;
        end else if (adv_s) begin
            a_re_r  <= data_a_i_i;
            a_im_r  <= data_a_q_i;
            b_re_r  <= data_b_i_i;
            b_im_r  <= data_b_q_i;
            conj1_r <= conj_i;
            v1_r    <= valid_i;
        end
    end

    // Stage 2: the four partial products.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            p_rr_r  <= '0;
            p_qq_r  <= '0;
            p_rq_r  <= '0;
            p_qr_r  <= '0;
            conj2_r <= 1'b0;
            v2_r    <= 1'b0;
        end else if (adv_s) begin
            p_rr_r  <= PROD_W'(a_re_r) * PROD_W'(b_re_r);
            p_qq_r  <= PROD_W'(a_im_r) * PROD_W'(b_im_r);
            p_rq_r  <= PROD_W'(a_re_r) * PROD_W'(b_im_r);
            p_qr_r  <= PROD_W'(a_im_r) * PROD_W'(b_re_r);
            conj2_r <= conj1_r;
            v2_r    <= v1_r;
        end
    end

    // Stage 3 combine at full precision; conj flips the sign of b's imaginary part.
    always_comb begin
        if (conj2_r) begin
            re_full_s = FULL_W'(p_rr_r) + FULL_W'(p_qq_r);
            im_full_s = FULL_W'(p_qr_r) - FULL_W'(p_rq_r);
        end else begin
            re_full_s = FULL_W'(p_rr_r) - FULL_W'(p_qq_r);
            im_full_s = FULL_W'(p_rq_r) + FULL_W'(p_qr_r);
        end
    end

    cmult_round_sat #(.FULL_W(FULL_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_re (
        .val_i (re_full_s),
        .res_o (re_res_s),
        .ovf_o (re_ovf_s)
    );

    cmult_round_sat #(.FULL_W(FULL_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_im (
        .val_i (im_full_s),
        .res_o (im_res_s),
        .ovf_o (im_ovf_s)
    );

    // Stage 3 output register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_i_o <= '0;
            data_q_o <= '0;
            valid_o  <= 1'b0;
        end else if (adv_s) begin
            data_i_o <= re_res_s;
            data_q_o <= im_res_s;
            valid_o  <= v2_r;
        end
    end

    // Sticky overflow: a new event beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_o <= 1'b0;
        end else if (adv_s && v2_r && (re_ovf_s || im_ovf_s)) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Directed bench for complex_mult_pipe: default build plus an OUT_W=18/SHIFT=17 instance
// sharing one stimulus; clamp expectations follow COMPLEX_MULT_SAT_EN.
module tb_complex_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic signed [17:0] a_re, a_im, b_re, b_im;
    logic               conj, valid_in, ready_in, ovf_clr;

    logic               ready_d, valid_d, ovf_d;
    logic signed [36:0] di_d, dq_d;
    logic               ready_s, valid_s, ovf_s;
    logic signed [17:0] di_s, dq_s;

    int n_cmp = 0;
    int n_err = 0;

`ifdef COMPLEX_MULT_SAT_EN
    localparam longint EXP_BIG_IM = 64'sd131071;
`else
    localparam longint EXP_BIG_IM = 64'sd0;
`endif

    complex_mult_pipe dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .data_a_i_i(a_re), .data_a_q_i(a_im), .data_b_i_i(b_re), .data_b_q_i(b_im),
        .conj_i(conj), .valid_i(valid_in), .ready_o(ready_d),
        .data_i_o(di_d), .data_q_o(dq_d), .valid_o(valid_d), .ready_i(ready_in),
        .ovf_o(ovf_d), .ovf_clr_i(ovf_clr)
    );

    complex_mult_pipe #(.IN_W(18), .OUT_W(18), .SHIFT(17)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n),
        .data_a_i_i(a_re), .data_a_q_i(a_im), .data_b_i_i(b_re), .data_b_q_i(b_im),
        .conj_i(conj), .valid_i(valid_in), .ready_o(ready_s),
        .data_i_o(di_s), .data_q_o(dq_s), .valid_o(valid_s), .ready_i(ready_in),
        .ovf_o(ovf_s), .ovf_clr_i(ovf_clr)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Send one sample with ready_i high and confirm it appears exactly 3 cycles later.
    task automatic run_one(input logic signed [17:0] ar, input logic signed [17:0] aq,
                           input logic signed [17:0] br, input logic signed [17:0] bq,
                           input logic cj, input string tag);
        @(negedge clk);
        a_re = ar; a_im = aq; b_re = br; b_im = bq; conj = cj;
        valid_in = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        check({tag, "_lat_early"}, longint'(valid_d), 64'sd0);
        @(negedge clk);
        check({tag, "_lat"}, longint'(valid_d), 64'sd1);
    endtask

    initial begin
        int in_idx;
        int out_idx;
        bit held;
        logic signed [36:0] hold_re, hold_im;

        rst_n = 1'b0; a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        conj = 1'b0; valid_in = 1'b0; ready_in = 1'b1; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", longint'(valid_d), 64'sd0);
        check("rst_re", longint'(di_d), 64'sd0);
        check("rst_im", longint'(dq_d), 64'sd0);
        check("rst_ovf", longint'(ovf_d), 64'sd0);
        check("rst_ready", longint'(ready_d), 64'sd1);
        rst_n = 1'b1;

        run_one(18'sd3, 18'sd4, 18'sd5, -18'sd2, 1'b0, "mul");
        check("mul_re", longint'(di_d), 64'sd23);
        check("mul_im", longint'(dq_d), 64'sd14);

        run_one(18'sd3, 18'sd4, 18'sd5, -18'sd2, 1'b1, "conj");
        check("conj_re", longint'(di_d), 64'sd7);
        check("conj_im", longint'(dq_d), 64'sd26);

        run_one(18'h20000, 18'h20000, 18'h20000, 18'h20000, 1'b0, "big");
        check("big_re", longint'(di_d), 64'sd0);
        check("big_im", longint'(dq_d), 64'sd34359738368);
        check("big_ovf", longint'(ovf_d), 64'sd0);
        check("big_s_re", longint'(di_s), 64'sd0);
        check("big_s_im", longint'(dq_s), EXP_BIG_IM);
        check("big_s_ovf", longint'(ovf_s), 64'sd1);

        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", longint'(ovf_s), 64'sd0);

        run_one(18'sd256, 18'sd0, 18'sd256, 18'sd0, 1'b0, "rnd_pos");
        check("rnd_pos_re", longint'(di_s), 64'sd1);
        check("rnd_pos_im", longint'(dq_s), 64'sd0);
        check("rnd_pos_full", longint'(di_d), 64'sd65536);

        run_one(-18'sd256, 18'sd0, 18'sd256, 18'sd0, 1'b0, "rnd_neg");
        check("rnd_neg_re", longint'(di_s), 64'sd0);
        check("rnd_neg_full", longint'(di_d), -64'sd65536);
        check("rnd_neg_ovf", longint'(ovf_s), 64'sd0);

        // Stream of 10: a=(k, k+1), b=(2, -1) gives (3k+1) + (k+2)j.
        in_idx = 0; out_idx = 0; held = 1'b0; hold_re = '0; hold_im = '0;
        for (int cyc = 0; cyc < 60 && out_idx < 10; cyc++) begin
            @(negedge clk);
            ready_in = !(cyc >= 6 && cyc < 10);
            #1;
            if (held) begin
                check("hold_re", longint'(di_d), longint'(hold_re));
                check("hold_im", longint'(dq_d), longint'(hold_im));
                held = 1'b0;
            end
            if (valid_d && !ready_in) begin
                check("stall_ready", longint'(ready_d), 64'sd0);
                hold_re = di_d; hold_im = dq_d; held = 1'b1;
            end else if (valid_d) begin
                check("stream_re", longint'(di_d), longint'(3 * out_idx + 1));
                check("stream_im", longint'(dq_d), longint'(out_idx + 2));
                out_idx++;
            end
            if (in_idx < 10) begin
                valid_in = 1'b1; conj = 1'b0;
                a_re = 18'(in_idx); a_im = 18'(in_idx + 1); b_re = 18'sd2; b_im = -18'sd1;
                if (ready_d) in_idx++;
            end else begin
                valid_in = 1'b0;
            end
        end
        check("stream_count", longint'(out_idx), 64'sd10);
        valid_in = 1'b0; ready_in = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stream_no_dup", longint'(valid_d), 64'sd0);
        end

        // Reset with samples in flight.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid_in = 1'b1; conj = 1'b0;
            a_re = 18'(100 + k); a_im = 18'sd0; b_re = 18'sd1; b_im = 18'sd0;
        end
        @(negedge clk);
        valid_in = 1'b0;
        check("pre_rst_valid", longint'(valid_d), 64'sd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", longint'(valid_d), 64'sd0);
        check("mid_rst_re", longint'(di_d), 64'sd0);
        check("mid_rst_im", longint'(dq_d), 64'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(18'sd3, 18'sd4, 18'sd5, -18'sd2, 1'b1, "post_rst");
        check("post_rst_re", longint'(di_d), 64'sd7);
        check("post_rst_im", longint'(dq_d), 64'sd26);
        @(negedge clk);
        check("post_rst_single", longint'(valid_d), 64'sd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
